// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: drives key-schedule writes and the round-by-round datapath controls.
// All outputs come from flops loaded with the decode of the next state.
module aes_round_ctrl #(
    parameter int unsigned NR = 10,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_op,
    input  logic          key_op,
    input  logic          ed_sel,
    input  logic          clear,
    output logic          key_we,
    output logic [AW-1:0] key_wr_addr,
    output logic [7:0]    rcon,
    output logic [AW-1:0] key_rd_addr,
    output logic          state_load,
    output logic          round_en,
    output logic          final_round,
    output logic          dec_mode,
    output logic          key_expanded,
    output logic          aes_done,
    output logic          keyed,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_EXPAND, S_KDONE, S_KEYED, S_LOAD, S_ROUND, S_FINAL, S_BDONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] kcnt_q, kcnt_d;
    logic [AW-1:0] rnd_q, rnd_d;
    logic          dec_d;

    logic          key_we_d, state_load_d, round_en_d, final_round_d;
    logic          key_expanded_d, aes_done_d, keyed_d, busy_d;
    logic [AW-1:0] key_wr_addr_d, key_rd_addr_d;
    logic [7:0]    rcon_d;

    // Round constant for key index; index 0 is the raw cipher key.
    function automatic logic [7:0] rcon_of(input logic [AW-1:0] idx);
        case (idx)
            AW'(1):  rcon_of = 8'h01;
            AW'(2):  rcon_of = 8'h02;
            AW'(3):  rcon_of = 8'h04;
            AW'(4):  rcon_of = 8'h08;
            AW'(5):  rcon_of = 8'h10;
            AW'(6):  rcon_of = 8'h20;
            AW'(7):  rcon_of = 8'h40;
            AW'(8):  rcon_of = 8'h80;
            AW'(9):  rcon_of = 8'h1B;
            AW'(10): rcon_of = 8'h36;
            default: rcon_of = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            kcnt_q       <= '0;
            rnd_q        <= '0;
            dec_mode     <= 1'b0;
            key_we       <= 1'b0;
            key_wr_addr  <= '0;
            rcon         <= 8'h00;
            key_rd_addr  <= '0;
            state_load   <= 1'b0;
            round_en     <= 1'b0;
            final_round  <= 1'b0;
            key_expanded <= 1'b0;
            aes_done     <= 1'b0;
            keyed        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            kcnt_q       <= kcnt_d;
            rnd_q        <= rnd_d;
            dec_mode     <= dec_d;
            key_we       <= key_we_d;
            key_wr_addr  <= key_wr_addr_d;
            rcon         <= rcon_d;
            key_rd_addr  <= key_rd_addr_d;
            state_load   <= state_load_d;
            round_en     <= round_en_d;
            final_round  <= final_round_d;
            key_expanded <= key_expanded_d;
            aes_done     <= aes_done_d;
            keyed        <= keyed_d;
            busy         <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kcnt_d  = kcnt_q;
        rnd_d   = rnd_q;
        dec_d   = dec_mode;

        if (clear) begin
            state_d = S_IDLE;
            kcnt_d  = '0;
            rnd_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_op) begin
                        state_d = S_EXPAND;
                        kcnt_d  = '0;
                    end
                end
                S_EXPAND: begin
                    if (kcnt_q == AW'(NR)) begin
                        state_d = S_KDONE;
                        kcnt_d  = '0;
                    end else begin
                        kcnt_d = kcnt_q + AW'(1);
                    end
                end
                S_KDONE: state_d = S_KEYED;
                S_KEYED: begin
                    // Re-expansion wins over a simultaneous block request.
                    if (start_op) begin
                        state_d = S_EXPAND;
                        kcnt_d  = '0;
                    end else if (key_op) begin
                        state_d = S_LOAD;
                        dec_d   = ~ed_sel;
                        rnd_d   = '0;
                    end
                end
                S_LOAD: begin
                    state_d = S_ROUND;
                    rnd_d   = AW'(1);
                end
                S_ROUND: begin
                    rnd_d = rnd_q + AW'(1);
                    if (rnd_q == AW'(NR - 1)) state_d = S_FINAL;
                end
                S_FINAL: begin
                    state_d = S_BDONE;
                    rnd_d   = '0;
                end
                S_BDONE: state_d = S_KEYED;
                default: state_d = S_IDLE;
            endcase
        end

        key_we_d       = (state_d == S_EXPAND);
        key_wr_addr_d  = key_we_d ? kcnt_d : '0;
        rcon_d         = key_we_d ? rcon_of(kcnt_d) : 8'h00;
        state_load_d   = (state_d == S_LOAD);
        round_en_d     = (state_d == S_ROUND);
        final_round_d  = (state_d == S_FINAL);
        key_expanded_d = (state_d == S_KDONE);
        aes_done_d     = (state_d == S_BDONE);
        keyed_d        = (state_d inside {S_KEYED, S_LOAD, S_ROUND, S_FINAL, S_BDONE});
        busy_d         = (state_d inside {S_EXPAND, S_KDONE, S_LOAD, S_ROUND, S_FINAL, S_BDONE});
        // Decryption walks the key schedule backwards from index NR.
        if (state_d inside {S_LOAD, S_ROUND, S_FINAL})
            key_rd_addr_d = dec_d ? (AW'(NR) - rnd_d) : rnd_d;
        else
            key_rd_addr_d = '0;
    end

endmodule
